dbg_case_panel: RTL
===================

// Module: dbg_case_panel
// PURPOSE
//  Parametrised front-panel controller for board tests. Selects a debug case with two buttons,
//  commits it to one or all of NUM_CHNLS debug links with a button chord, and picks which link's
//  leds/digits are shown. It sits between the debounced switches and the dbg links of the DUTs,
//  and feeds bin_to_disp and the board LEDs.
// PARAMETERS
//  NUM_CHNLS   2    debug links driven; 1..8
//  CHSEL_SZ    3    width of channel select; must hold NUM_CHNLS (broadcast code)
//  HI_MAX      16   case_hi wraps to 0 after HI_MAX-1; 1..16
//  LO_MAX      16   case_lo wraps to 0 after LO_MAX-1; 1..16
//  DOIT_CKS    4    cycles o_dbg_doit stays high per commit; >=1
//  INIT_DISP   7    value shown on both digits out of reset (test number)
// PORTS
//  i_clk        in   1              single clock; every flop on posedge
//  reset        in   1              synchronous, active-low
//  i_sw_hi      in   1              debounced level, 1 = pressed
//  i_sw_lo      in   1              debounced level, 1 = pressed
//  i_sw_ch      in   1              debounced level, 1 = pressed
//  o_dbg_case   out  8              {case_hi, case_lo}; shared by all links
//  o_dbg_doit   out  NUM_CHNLS      per-link commit strobe
//  i_dbg_leds   in   4*NUM_CHNLS    link k occupies bits [4k+3:4k]
//  i_dbg_disp0  in   4*NUM_CHNLS    link k occupies bits [4k+3:4k]
//  i_dbg_disp1  in   4*NUM_CHNLS    link k occupies bits [4k+3:4k]
//  o_leds       out  4              to board LEDs
//  o_disp0      out  4              to bin_to_disp, digit 0
//  o_disp1      out  4              to bin_to_disp, digit 1
//  o_chnl_sel   out  CHSEL_SZ       shown/target link; value NUM_CHNLS = broadcast
//  o_selecting  out  1              high while in SELECT
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - case_hi/lo = 0, o_dbg_doit = 0, o_chnl_sel = 0, o_leds = 0, o_disp0/1 = INIT_DISP.
//   - State = SHOW. Switch history = 0. chord flag = 0.
//   - Applies even mid-COMMIT: doit drops on the next edge.
//  Events: a release is the registered level 1 while the current level is 0. Decisions use the
//   release plus the other switch's registered level. All outputs are registered, so latency
//   from the releasing edge to the output is 1 cycle.
//  FSM states: SHOW, SELECT, COMMIT.
//   - hi release, lo not held, chord=0: case_hi = (case_hi==HI_MAX-1) ? 0 : case_hi+1; ->SELECT.
//   - lo release, hi not held, chord=0: same with LO_MAX; ->SELECT.
//   - Chord: hi released while lo held, lo released while hi held, or both released on the same
//     cycle. Effect: chord=1, case unchanged.
//       From SELECT: ->COMMIT, doit_cnt=DOIT_CKS.
//       From SHOW: re-commits the current case the same way.
//   - The later release that ends a chord clears chord and is otherwise ignored.
//   - ch release in SHOW: o_chnl_sel increments, wrapping NUM_CHNLS -> 0 (the NUM_CHNLS value is
//     broadcast). Ignored in SELECT and COMMIT.
//   - COMMIT: o_dbg_doit = one-hot(o_chnl_sel), or all ones when broadcast, for exactly DOIT_CKS
//     cycles. Then doit = 0 and state ->SHOW. o_dbg_case is frozen while in COMMIT (hi/lo
//     releases ignored).
//  Display:
//   - SELECT: o_leds = 0, o_disp0 = case_hi, o_disp1 = case_lo.
//   - SHOW/COMMIT: the dbg fields of link o_chnl_sel; link 0 when broadcast.
//  Arithmetic: all counters are unsigned, with explicit wrap; no overflow beyond the stated limits.
// STRUCTURE
//  - hglobal.v holds NS_ON/NS_OFF, the state encodings and the NS_INC_IDX wrap macro.
//  - One sub-module, dbg_rel_edge (level register + release pulse), instantiated 3x.
//  - The FSM, counters and display mux stay in this block.
// TESTING
//  1. Hold reset low 3 cycles -> disp0=disp1=7, leds=0, doit=0, sel=0, state SHOW.
//  2. Release hi 3 times -> o_dbg_case=8'h30, o_selecting=1, disp0=3, disp1=0, leds=0.
//  3. From 2, press hi, press lo, release both same cycle -> o_dbg_doit=2'b01 for exactly 4
//     cycles, then SHOW with link-0 digits.
//  4. LO_MAX=3: release lo 4 times -> case_lo sequence 1,2,0,1.
//  5. Release ch twice (NUM_CHNLS=2) -> sel=2 (broadcast). Chord -> doit=2'b11 for 4 cycles.
//     Display shows link 0.
//  6. Reset low during COMMIT cycle 2 -> doit=0 next edge, case=0. Ch release in SELECT -> sel
//     unchanged.

Source files
------------

// File: rtl/dbg_case_panel_pkg.sv
// Shared types and helpers for the debug case front panel.
package dbg_case_panel_pkg;

  typedef enum logic [1:0] {
    ST_SHOW   = 2'd0,
    ST_SELECT = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Increment a 4-bit digit, wrapping to 0 after max-1.
  function automatic logic [3:0] inc_wrap(input logic [3:0] v, input int unsigned max);
    return (32'(v) == max - 1) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/dbg_rel_edge.sv
// Registers a debounced switch level and flags its release (1 -> 0).
module dbg_rel_edge (
  input  logic i_clk,
  input  logic reset,
  input  logic sw_i,
  output logic lvl_o,
  output logic rel_o
);

  logic lvl_q;

  // Level history; cleared by reset so no spurious release follows it.
  always_ff @(posedge i_clk) begin
    if (!reset) lvl_q <= 1'b0;
    else        lvl_q <= sw_i;
  end

  assign lvl_o = lvl_q;
  assign rel_o = lvl_q & ~sw_i;

endmodule

// File: rtl/dbg_case_panel.sv
// Front-panel controller: picks a debug case with hi/lo buttons, commits it to
// one or all links with a hi+lo chord, and muxes the shown link's leds/digits.
module dbg_case_panel
  import dbg_case_panel_pkg::*;
#(
  parameter int NUM_CHNLS = 2,
  parameter int CHSEL_SZ  = 3,
  parameter int HI_MAX    = 16,
  parameter int LO_MAX    = 16,
  parameter int DOIT_CKS  = 4,
  parameter int INIT_DISP = 7
) (
  input  logic                     i_clk,
  input  logic                     reset,
  input  logic                     i_sw_hi,
  input  logic                     i_sw_lo,
  input  logic                     i_sw_ch,
  output logic [7:0]               o_dbg_case,
  output logic [NUM_CHNLS-1:0]     o_dbg_doit,
  input  logic [4*NUM_CHNLS-1:0]   i_dbg_leds,
  input  logic [4*NUM_CHNLS-1:0]   i_dbg_disp0,
  input  logic [4*NUM_CHNLS-1:0]   i_dbg_disp1,
  output logic [3:0]               o_leds,
  output logic [3:0]               o_disp0,
  output logic [3:0]               o_disp1,
  output logic [CHSEL_SZ-1:0]      o_chnl_sel,
  output logic                     o_selecting
);

  localparam int CW = $clog2(DOIT_CKS + 1);
  localparam logic [CHSEL_SZ-1:0] BCAST = CHSEL_SZ'(NUM_CHNLS);

  logic hi_lvl, hi_rel, lo_lvl, lo_rel, ch_rel, ch_lvl_unused;

  dbg_rel_edge u_hi (.i_clk(i_clk), .reset(reset), .sw_i(i_sw_hi), .lvl_o(hi_lvl),        .rel_o(hi_rel));
  dbg_rel_edge u_lo (.i_clk(i_clk), .reset(reset), .sw_i(i_sw_lo), .lvl_o(lo_lvl),        .rel_o(lo_rel));
  dbg_rel_edge u_ch (.i_clk(i_clk), .reset(reset), .sw_i(i_sw_ch), .lvl_o(ch_lvl_unused), .rel_o(ch_rel));

  state_e                state_q, state_d;
  logic [3:0]            hi_q, hi_d, lo_q, lo_d;
  logic [CHSEL_SZ-1:0]   sel_q, sel_d, lnk;
  logic                  chord_q, chord_d, chord_evt, bcast;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_CHNLS-1:0]  doit_q, doit_d;
  logic [3:0]            leds_q, leds_d, disp0_q, disp0_d, disp1_q, disp1_d;

  // Next-state: channel select, chord/commit, case stepping, commit timer, display mux.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sel_d     = sel_q;
    chord_d   = chord_q;
    cnt_d     = cnt_q;
    doit_d    = doit_q;
    leds_d    = i_dbg_leds[3:0];
    disp0_d   = i_dbg_disp0[3:0];
    disp1_d   = i_dbg_disp1[3:0];
    // Simultaneous release is covered: the other level is still registered high.
    chord_evt = (hi_rel & lo_lvl) | (lo_rel & hi_lvl);

    if (ch_rel && state_q == ST_SHOW)
      sel_d = (sel_q == BCAST) ? '0 : sel_q + 1'b1;
    bcast = (sel_d == BCAST);
    lnk   = bcast ? '0 : sel_d;

    if (chord_q && (hi_rel || lo_rel)) begin
      // Tail release of an earlier chord: only ends the chord.
      chord_d = 1'b0;
    end else if (chord_evt) begin
      // A chord released by both buttons at once leaves nothing pending.
      chord_d = ~(hi_rel & lo_rel);
      if (state_q != ST_COMMIT) begin
        state_d = ST_COMMIT;
        cnt_d   = CW'(DOIT_CKS);
        for (int k = 0; k < NUM_CHNLS; k++)
          doit_d[k] = bcast | (sel_d == CHSEL_SZ'(k));
      end
    end else if (state_q != ST_COMMIT) begin
      if (hi_rel) begin
        hi_d    = inc_wrap(hi_q, HI_MAX);
        state_d = ST_SELECT;
      end else if (lo_rel) begin
        lo_d    = inc_wrap(lo_q, LO_MAX);
        state_d = ST_SELECT;
      end
    end

    if (state_q == ST_COMMIT) begin
      if (cnt_q == CW'(1)) begin
        state_d = ST_SHOW;
        doit_d  = '0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (state_d == ST_SELECT) begin
      leds_d  = 4'd0;
      disp0_d = hi_d;
      disp1_d = lo_d;
    end else begin
      for (int k = 0; k < NUM_CHNLS; k++) begin
        if (lnk == CHSEL_SZ'(k)) begin
          leds_d  = i_dbg_leds[4*k +: 4];
          disp0_d = i_dbg_disp0[4*k +: 4];
          disp1_d = i_dbg_disp1[4*k +: 4];
        end
      end
    end
  end

  // State and output registers; reset wins even mid-commit.
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q <= ST_SHOW;
      hi_q    <= '0;
      lo_q    <= '0;
      sel_q   <= '0;
      chord_q <= 1'b0;
      cnt_q   <= '0;
      doit_q  <= '0;
      leds_q  <= '0;
      disp0_q <= 4'(INIT_DISP);
      disp1_q <= 4'(INIT_DISP);
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sel_q   <= sel_d;
      chord_q <= chord_d;
      cnt_q   <= cnt_d;
      doit_q  <= doit_d;
      leds_q  <= leds_d;
      disp0_q <= disp0_d;
      disp1_q <= disp1_d;
    end
  end

  assign o_dbg_case  = {hi_q, lo_q};
  assign o_dbg_doit  = doit_q;
  assign o_chnl_sel  = sel_q;
  assign o_selecting = (state_q == ST_SELECT);
  assign o_leds      = leds_q;
  assign o_disp0     = disp0_q;
  assign o_disp1     = disp1_q;

endmodule
